// File: rtl/req_encoder.sv
// Sequential 8-to-3 request encoder: accepts a request vector, then streams the index of each set bit, lowest first.
// Optional ZERO_FLAG_EN: an accepted all-zero vector produces a single beat flagged by o_zero instead of being dropped.
module req_encoder (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [2:0] o_y,
  output logic       o_last,
  output logic       o_zero
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_pending;
  logic [7:0] w_nextPending;
  logic [2:0] w_lowIdx;
  logic       w_single;
  logic       w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_nextState;
      r_pending <= w_nextPending;
    end
  end

`ifdef ZERO_FLAG_EN
  logic r_zero;

  // Remembers that the current EMIT beat stands for an all-zero vector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zero <= 1'b0;
    end else if (r_state == IDLE && i_in_valid && i_in == 8'd0) begin
      r_zero <= 1'b1;
    end else if (r_state == EMIT && i_out_ready) begin
      r_zero <= 1'b0;
    end
  end
`endif

  // Index and last-flag come from the registered pending vector only.
  always_comb begin
    w_lowIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_lowIdx = 3'(i);
    end
    w_single = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);
`ifdef ZERO_FLAG_EN
    w_last = w_single || r_zero;
`else
    w_last = w_single;
`endif
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextPending = r_pending;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_nextPending = i_in;
`ifdef ZERO_FLAG_EN
          w_nextState = EMIT;
`else
          if (i_in != 8'd0) w_nextState = EMIT;
`endif
        end
      end
      EMIT: begin
        if (i_out_ready) begin
          w_nextPending = r_pending & (r_pending - 8'd1);
          if (w_last) w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == IDLE);
    o_out_valid = (r_state == EMIT);
    o_y         = (r_state == EMIT) ? w_lowIdx : 3'd0;
    o_last      = (r_state == EMIT) && w_last;
`ifdef ZERO_FLAG_EN
    o_zero      = (r_state == EMIT) && r_zero;
`else
    o_zero      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: directed vector table with hand-derived expectations, then random traffic
// checked against a queue-of-indices reference model.
module tb_req_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] din;
  logic       outValid;
  logic       outReady;
  logic [2:0] y;
  logic       last;
  logic       zero;

  int total = 0;
  int bad   = 0;

  // Reference model: the indices still owed to the consumer, lowest first.
  int  modelQ[$];
  bit  modelZero = 1'b0;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    bit         chk;
    logic       eRdy;
    logic       eVal;
    logic [2:0] eY;
    logic       eLast;
    logic       eZero;
  } vec_t;

  vec_t vecs[$];

  req_encoder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in        (din),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_y         (y),
    .o_last      (last),
    .o_zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic void addVec(logic r, logic iv, logic [7:0] d, logic ordy, bit chk,
                                 logic eRdy, logic eVal, logic [2:0] eY, logic eLast, logic eZero);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy; v.chk = chk;
    v.eRdy = eRdy; v.eVal = eVal; v.eY = eY; v.eLast = eLast; v.eZero = eZero;
    vecs.push_back(v);
  endfunction

  task automatic check1(string nm, int idx, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic checkOutput(int idx, logic eRdy, logic eVal, logic [2:0] eY, logic eLast, logic eZero);
    check1("in_ready",  idx, 8'(inReady),  8'(eRdy));
    check1("out_valid", idx, 8'(outValid), 8'(eVal));
    check1("y",         idx, 8'(y),        8'(eY));
    check1("last",      idx, 8'(last),     8'(eLast));
    check1("zero",      idx, 8'(zero),     8'(eZero));
  endtask

  function automatic void modelEdge(logic r, logic iv, logic [7:0] d, logic ordy);
    if (r) begin
      modelQ.delete();
      modelZero = 1'b0;
    end else if (modelQ.size() > 0) begin
      if (ordy) begin
        void'(modelQ.pop_front());
        if (modelQ.size() == 0) modelZero = 1'b0;
      end
    end else if (iv) begin
      for (int i = 0; i < 8; i++) if (d[i]) modelQ.push_back(i);
`ifdef ZERO_FLAG_EN
      if (d == 8'd0) begin
        modelQ.push_back(0);
        modelZero = 1'b1;
      end
`endif
    end
  endfunction

  // Drives one cycle of inputs; outputs reflect state registered before this cycle's edge.
  task automatic applyStimulus(logic r, logic iv, logic [7:0] d, logic ordy);
    rst = r; inValid = iv; din = d; outReady = ordy;
    #2;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelEdge(rst, inValid, din, outReady);
    #1;
  endtask

  initial begin
    logic       r, iv, ordy;
    logic [7:0] d;
    int         pick;
    logic       mVal;

    // Reset held with a full request pending on the input.
    addVec(1, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    // Multi-bit vector streamed at full rate.
    addVec(0, 1, 8'hA5, 1, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 2, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 5, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 7, 1, 0);
    addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    // Backpressure on a single-bit vector.
    addVec(0, 1, 8'h80, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 0, 1, 0, 1, 7, 1, 0);
    addVec(0, 0, 8'h00, 0, 1, 0, 1, 7, 1, 0);
    addVec(0, 0, 8'h00, 0, 1, 0, 1, 7, 1, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 7, 1, 0);
    addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    // New vector offered while busy, including on the final handshake.
    addVec(0, 1, 8'h06, 1, 1, 1, 0, 0, 0, 0);
    addVec(0, 1, 8'h01, 1, 1, 0, 1, 1, 0, 0);
    addVec(0, 1, 8'h01, 1, 1, 0, 1, 2, 1, 0);
    addVec(0, 1, 8'h01, 1, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 0, 1, 0);
    addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    // All-zero vector.
    addVec(0, 1, 8'h00, 1, 1, 1, 0, 0, 0, 0);
`ifdef ZERO_FLAG_EN
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 0, 1, 1);
`else
    addVec(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0);
`endif
    addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    // Reset in the middle of a stream.
    addVec(0, 1, 8'hFF, 1, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 1, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 0, 1, 2, 0, 0);
    addVec(1, 0, 8'h00, 1, 1, 0, 1, 3, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0);

    rst = 1'b1; inValid = 1'b0; din = 8'h00; outReady = 1'b0;

    $display("[TB] directed table: %0d steps", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      if (vecs[i].chk)
        checkOutput(i, vecs[i].eRdy, vecs[i].eVal, vecs[i].eY, vecs[i].eLast, vecs[i].eZero);
      finishCycle();
    end

    $display("[TB] random traffic against reference model");
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 59) == 0);
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 9) < 7);
      pick = $urandom_range(0, 9);
      if (pick < 2)      d = 8'h00;
      else if (pick < 4) d = 8'd1 << $urandom_range(0, 7);
      else               d = 8'($urandom);
      applyStimulus(r, iv, d, ordy);
      mVal = (modelQ.size() > 0);
      checkOutput(1000 + n, !mVal, mVal,
                  mVal ? 3'(modelQ[0]) : 3'd0,
                  modelQ.size() == 1,
                  mVal && modelZero);
      finishCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
# req_encoder

Sequential 8-to-3 request encoder, the inverse of the team's 3-to-8 one-hot decoder. It accepts an 8-bit request vector over a valid/ready handshake. It then emits the 3-bit index of every set bit, lowest index first, one index per output handshake, and marks the final index with `last`. It sits between request-collecting logic and any consumer that needs binary indices, such as the decoder, a mux select or a register-file address.

## Interface
- Parameters: none. Width is fixed at 8 request lines and a 3-bit index.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request vector `in` is valid.
- `in_ready`  out  1  block is idle and accepts a vector; high exactly when the state is IDLE.
- `in`  in  8  request vector; bit i set means index i is requested.
- `out_valid`  out  1  `y` holds a valid index.
- `out_ready`  in  1  consumer accepts the current index.
- `y`  out  3  binary index of the lowest pending request bit.
- `last`  out  1  current `y` is the final index of the captured vector.
- `zero`  out  1  current beat reports an all-zero vector; only driven when `ZERO_FLAG_EN` is defined.

## Operation
- State: 2-state FSM {IDLE, EMIT} plus an 8-bit `pending` register.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&&`in_ready`, capture `in` into `pending`.
  - If `in`≠0, go to EMIT.
  - If `in`==0, the outcome depends on `ZERO_FLAG_EN` (see Configuration).
- EMIT:
  - `out_valid`=1, `in_ready`=0.
  - `y` = index of the lowest set bit of `pending`.
  - `last` = 1 when exactly one bit of `pending` is set.
- EMIT handshake (`out_valid`&&`out_ready`):
  - Clear bit `y` of `pending`.
  - If `last`=1, go to IDLE; otherwise stay in EMIT.
- Backpressure: while `out_valid`&&!`out_ready`, `pending`, `y` and `last` hold stable.
- `in` and `in_valid` are ignored while `in_ready`=0; a source holding `in_valid` is accepted on the first IDLE cycle.
- When `out_valid`=0: `y`=0, `last`=0, `zero`=0.
- `y` and `last` are decoded from the registered `pending` only, with no combinational path from `in` or `out_ready` to any output.
- Reset values: state IDLE, `pending`=0, `out_valid`=0, `y`=0, `last`=0, `zero`=0. `in_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-operation: `rst` high at an edge discards `pending`. `out_valid` is 0 in the following cycle and no remaining indices are emitted.
- `rst` has priority over every handshake in the same cycle.

## Timing
- Capture latency: vector accepted at edge N → `out_valid`=1 during cycle N+1.
- Throughput: with `out_ready` held high, one index per cycle. A vector with k set bits occupies EMIT for exactly k cycles.
- Turnaround: the final handshake at edge M returns to IDLE, so `in_ready`=1 during cycle M+1. The next vector is accepted at edge M+1 at the earliest.
- Minimum period between vector acceptances: k+1 cycles.
- Simultaneous `in_valid` and final output handshake in the same cycle: `in` is not accepted, because `in_ready`=0 in EMIT.

## Configuration
- Macro: `ZERO_FLAG_EN`.
- Defined:
  - An accepted all-zero vector enters EMIT for one beat with `y`=0, `last`=1, `zero`=1.
  - After that handshake, return to IDLE.
  - `zero`=0 on all other beats.
- Undefined:
  - An accepted all-zero vector is dropped; the FSM stays in IDLE.
  - No output beat, and `in_ready` stays 1.
  - `zero` is tied to 0.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 and `in`=8'hFF → `out_valid`=0, `y`=0, `last`=0 throughout; `in_ready`=1 in the cycle after release.
- Multi-bit: accept `in`=8'b1010_0101 with `out_ready`=1 → `y`=0,2,5,7 on 4 consecutive cycles; `last`=1 only with `y`=7; `in_ready`=1 on the cycle after.
- Backpressure: accept `in`=8'h80, hold `out_ready`=0 for 3 cycles → `y`=7, `last`=1, `out_valid`=1 stable all 3 cycles; one handshake when `out_ready`=1, then IDLE.
- Busy input: accept 8'h06, then present 8'h01 with `in_valid`=1 during EMIT → 8'h01 ignored until IDLE; stream is `y`=1, 2(`last`), then `y`=0(`last`).
- Zero vector: accept 8'h00 → with `ZERO_FLAG_EN`, one beat `y`=0, `last`=1, `zero`=1; without it, `out_valid` stays 0 and `in_ready` stays 1.
- Reset mid-operation: accept 8'hFF, complete 3 beats (`y`=0,1,2), assert `rst` → `out_valid`=0 next cycle; after release no further beats and `in_ready`=1.
